// File: rtl/encoder_rm28md_axi_slave.sv
// AXI4-Lite slave for the RM28MD quadrature encoder: x4 decoder, 32-bit position
// counter, index capture and sticky status, exposed as CTRL/COUNT/INDEX/STATUS.
module encoder_rm28md_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int SYNC_STAGES        = 2
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    input  logic                            enc_a,
    input  logic                            enc_b,
    input  logic                            enc_i
);

    localparam int DW = C_S_AXI_DATA_WIDTH;

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_COUNT  = 2'd1;
    localparam logic [1:0] SEL_INDEX  = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [SYNC_STAGES-1:0] sync_i;

    logic [1:0]    ab_now;
    logic [1:0]    ab_prev;
    logic          i_now;
    logic          i_prev;
    logic          primed;

    logic          ctrl_en;
    logic          ctrl_dir_inv;
    logic [DW-1:0] count;
    logic [DW-1:0] index_cap;
    logic          status_err;
    logic          status_idx;

    logic          step_fwd;
    logic          step_rev;
    logic          illegal;
    logic          count_up;
    logic          count_dn;
    logic          idx_edge;

    logic          wr_en;
    logic [1:0]    wr_sel;
    logic [1:0]    rd_sel;
    logic          clr_req;
    logic [1:0]    status_w1c;
    logic [DW-1:0] rd_mux;

    // Inputs and address bits that carry no meaning in this register map.
    logic unused_ok;
    assign unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot, s00_axi_wstrb,
                         s00_axi_wdata, s00_axi_awaddr, s00_axi_araddr};

    assign s00_axi_bresp = 2'b00;
    assign s00_axi_rresp = 2'b00;

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            sync_a <= '0;
            sync_b <= '0;
            sync_i <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], enc_a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], enc_b};
            sync_i <= {sync_i[SYNC_STAGES-2:0], enc_i};
        end
    end

    assign ab_now = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
    assign i_now  = sync_i[SYNC_STAGES-1];

    // Gray order 00 -> 01 -> 11 -> 10 -> 00 is forward; a two-bit jump is illegal.
    always_comb begin
        step_fwd = 1'b0;
        step_rev = 1'b0;
        illegal  = 1'b0;
        if (primed && (ab_now != ab_prev)) begin
            case ({ab_prev, ab_now})
                4'b0001, 4'b0111, 4'b1110, 4'b1000: step_fwd = 1'b1;
                4'b0100, 4'b1101, 4'b1011, 4'b0010: step_rev = 1'b1;
                default:                            illegal  = 1'b1;
            endcase
        end
    end

    assign count_up = ctrl_en && (ctrl_dir_inv ? step_rev : step_fwd);
    assign count_dn = ctrl_en && (ctrl_dir_inv ? step_fwd : step_rev);
    assign idx_edge = primed && ctrl_en && i_now && !i_prev;

    assign wr_en      = s00_axi_awready && s00_axi_awvalid && s00_axi_wready && s00_axi_wvalid;
    assign wr_sel     = s00_axi_awaddr[3:2];
    assign rd_sel     = s00_axi_araddr[3:2];
    assign clr_req    = wr_en && (wr_sel == SEL_CTRL) && s00_axi_wstrb[0] && s00_axi_wdata[2];
    assign status_w1c = (wr_en && (wr_sel == SEL_STATUS) && s00_axi_wstrb[0])
                        ? s00_axi_wdata[1:0] : 2'b00;

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            ctrl_en      <= 1'b0;
            ctrl_dir_inv <= 1'b0;
            count        <= '0;
            index_cap    <= '0;
            status_err   <= 1'b0;
            status_idx   <= 1'b0;
            ab_prev      <= 2'b00;
            i_prev       <= 1'b0;
            primed       <= 1'b0;
        end else begin
            if (wr_en && (wr_sel == SEL_CTRL) && s00_axi_wstrb[0]) begin
                ctrl_en      <= s00_axi_wdata[0];
                ctrl_dir_inv <= s00_axi_wdata[1];
            end

            if (clr_req) begin
                count <= '0;
            end else if (count_up) begin
                count <= count + 1'b1;
            end else if (count_dn) begin
                count <= count - 1'b1;
            end

            // Captures the pre-step value when an index edge and a step coincide.
            if (idx_edge) begin
                index_cap <= count;
            end

            status_err <= illegal  | (status_err & ~status_w1c[0]);
            status_idx <= idx_edge | (status_idx & ~status_w1c[1]);

            ab_prev <= ab_now;
            i_prev  <= i_now;
            primed  <= 1'b1;
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
        end else begin
            s00_axi_awready <= s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid
                               && !s00_axi_awready;
            s00_axi_wready  <= s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid
                               && !s00_axi_awready;
            if (wr_en) begin
                s00_axi_bvalid <= 1'b1;
            end else if (s00_axi_bvalid && s00_axi_bready) begin
                s00_axi_bvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            SEL_CTRL:   rd_mux = {{(DW-2){1'b0}}, ctrl_dir_inv, ctrl_en};
            SEL_COUNT:  rd_mux = count;
            SEL_INDEX:  rd_mux = index_cap;
            SEL_STATUS: rd_mux = {{(DW-2){1'b0}}, status_idx, status_err};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
        end else begin
            s00_axi_arready <= s00_axi_arvalid && !s00_axi_rvalid && !s00_axi_arready;
            if (s00_axi_arready && s00_axi_arvalid) begin
                s00_axi_rdata  <= rd_mux;
                s00_axi_rvalid <= 1'b1;
            end else if (s00_axi_rvalid && s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_encoder_rm28md_axi_slave.sv
// Directed bench for encoder_rm28md_axi_slave: AXI-Lite master tasks, encoder pin
// driver with a position model, and a read scoreboard of expected register values.
module tb_encoder_rm28md_axi_slave;

    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        enc_a;
    logic        enc_b;
    logic        enc_i;

    int errors = 0;
    int checks = 0;

    logic [31:0] sb_q[$];
    string       tag_q[$];

    int          pos = 0;
    logic [31:0] exp_count = 32'h0;
    bit          m_en = 1'b0;
    bit          m_inv = 1'b0;

    always #5 clk = ~clk;

    encoder_rm28md_axi_slave dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (areset),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .enc_a           (enc_a),
        .enc_b           (enc_b),
        .enc_i           (enc_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [1:0] gray(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // dir = +1 forward Gray step, -1 reverse
    task automatic step(input int dir, input int wait_c);
        @(negedge clk);
        pos = (pos + 4 + dir) % 4;
        {enc_a, enc_b} = gray(pos);
        if (m_en) exp_count = exp_count + ((m_inv ? -dir : dir));
        repeat (wait_c) @(negedge clk);
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int hold, input bit no_resp);
        int  n;
        bit  held;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while (!(awready && wready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wr_accept", {31'b0, awready && wready}, 32'h1);
        @(posedge clk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
        if (addr[3:2] == 2'd0 && strb[0]) begin
            m_en  = data[0];
            m_inv = data[1];
            if (data[2]) exp_count = 32'h0;
        end
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bvalid_rise", {31'b0, bvalid}, 32'h1);
        check("bresp", {30'b0, bresp}, 32'h0);
        if (!no_resp) begin
            held = 1'b1;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                held = held & bvalid;
            end
            if (hold > 0) check("bvalid_held", {31'b0, held}, 32'h1);
            @(negedge clk);
            bready = 1'b1;
            @(posedge clk);
            #1;
            bready = 1'b0;
            check("bvalid_drop", {31'b0, bvalid}, 32'h0);
        end
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] expv,
                            input string tag, input int hold);
        int          n;
        logic [31:0] first;
        logic [31:0] e;
        string       t;
        bit          stable;
        sb_q.push_back(expv);
        tag_q.push_back(tag);
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rd_accept", {31'b0, arready}, 32'h1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rvalid_rise", {31'b0, rvalid}, 32'h1);
        first = rdata;
        stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            stable = stable & rvalid & (rdata === first);
        end
        if (hold > 0) check("rdata_stable", {31'b0, stable}, 32'h1);
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check(t, rdata, e);
        check("rresp", {30'b0, rresp}, 32'h0);
        @(negedge clk);
        rready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;
        check("rvalid_drop", {31'b0, rvalid}, 32'h0);
    endtask

    initial begin
        areset = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        enc_a = 1'b0; enc_b = 1'b0; enc_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_awready", {31'b0, awready}, 32'h0);
        check("rst_wready", {31'b0, wready}, 32'h0);
        check("rst_bvalid", {31'b0, bvalid}, 32'h0);
        check("rst_arready", {31'b0, arready}, 32'h0);
        check("rst_rvalid", {31'b0, rvalid}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        areset = 1'b0;
        repeat (2) @(negedge clk);

        axi_read(4'h0, 32'h0, "rst_ctrl", 0);
        axi_read(4'h4, 32'h0, "rst_count", 0);
        axi_read(4'h8, 32'h0, "rst_index", 0);
        axi_read(4'hC, 32'h0, "rst_status", 0);

        axi_write(4'h0, 32'hFFFF_FFFF, 4'hF, 5, 1'b0);
        axi_read(4'h0, 32'h0000_0003, "ctrl_mask", 3);

        axi_write(4'h0, 32'h1, 4'hF, 0, 1'b0);
        for (int k = 0; k < 8; k++) step(1, 4);
        axi_read(4'h4, exp_count, "count_fwd8", 0);

        axi_write(4'h0, 32'h3, 4'hF, 0, 1'b0);
        for (int k = 0; k < 8; k++) step(1, 4);
        axi_read(4'h4, exp_count, "count_inv8", 0);

        axi_write(4'h0, 32'h1, 4'hF, 0, 1'b0);
        for (int k = 0; k < 2; k++) step(1, 4);
        axi_write(4'h4, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
        axi_read(4'h4, exp_count, "count_ro", 0);

        step(1, 0);
        axi_write(4'h0, 32'h5, 4'hF, 0, 1'b0);
        repeat (4) @(negedge clk);
        axi_read(4'h4, exp_count, "count_clr_step", 0);
        axi_read(4'h0, 32'h1, "ctrl_clr_selfclear", 0);

        for (int k = 0; k < 3; k++) step(-1, 4);
        axi_read(4'h4, exp_count, "count_rev3", 0);

        @(negedge clk);
        enc_i = 1'b1;
        repeat (6) @(negedge clk);
        enc_i = 1'b0;
        repeat (6) @(negedge clk);
        axi_read(4'h8, 32'hFFFF_FFFD, "index_cap", 0);
        axi_read(4'hC, 32'h2, "status_idx", 0);
        axi_write(4'hC, 32'h2, 4'h1, 0, 1'b0);
        axi_read(4'hC, 32'h0, "status_idx_w1c", 0);

        @(negedge clk);
        pos = (pos + 2) % 4;
        {enc_a, enc_b} = gray(pos);
        repeat (6) @(negedge clk);
        axi_read(4'hC, 32'h1, "status_err", 0);
        axi_read(4'h4, exp_count, "count_after_err", 0);
        axi_write(4'hC, 32'h1, 4'h1, 0, 1'b0);
        axi_read(4'hC, 32'h0, "status_err_w1c", 0);

        while (pos != 0) step(1, 4);
        repeat (4) @(negedge clk);
        axi_read(4'h4, exp_count, "count_park", 0);

        axi_write(4'h0, 32'h1, 4'hF, 0, 1'b1);
        @(negedge clk);
        areset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_bvalid", {31'b0, bvalid}, 32'h0);
        @(negedge clk);
        areset = 1'b0;
        m_en = 1'b0; m_inv = 1'b0; exp_count = 32'h0;
        repeat (4) @(negedge clk);
        axi_read(4'h0, 32'h0, "post_rst_ctrl", 0);
        axi_read(4'h4, 32'h0, "post_rst_count", 0);
        axi_read(4'h8, 32'h0, "post_rst_index", 0);
        axi_read(4'hC, 32'h0, "post_rst_status", 0);

        check("sb_empty", sb_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
